pe_ctx_sequencer: RTL and testbench

Context sequencer for one PE. It holds up to DEPTH 48-bit PE instruction words (fu_opcode[47:44], switch_9x7[43:16], switch_5x4[15:4], reg_file_sel[3:0]). On start it issues them in order to the PE `inst` port, one per unstalled cycle, and replays the sequence for a programmed number of iterations. It sits between the array configuration loader and a PE instance, and replaces the static per-PE instruction drive.

---
 rtl/pe_ctx_sequencer.sv | 135 +++++++++++++
 tb/tb_pe_ctx_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_ctx_sequencer.sv
// Per-PE context sequencer: stores DEPTH instruction words and replays them to the PE.
// Optional abort input is enabled by defining PE_SEQ_ABORT_EN.
module pe_ctx_sequencer #(
  parameter int INST_W = 48,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int ITW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [INST_W-1:0] cfg_data,
  input  logic              start,
  input  logic [AW:0]       ctx_len,
  input  logic [ITW-1:0]    iter_num,
  input  logic              stall,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef PE_SEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [INST_W-1:0]   mem [DEPTH];
  logic [AW:0]         len;
  logic [ITW-1:0]      iter, iter_eff;
  logic [AW:0]         start_len;
  logic [ITW-1:0]      start_iter;
  logic [AW-1:0]       pc_inc;
  logic                last_ctx, last_iter;
  logic                abort_i;

`ifdef PE_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Launch parameters are clamped once, at the start pulse
  assign start_len  = (ctx_len > DEPTH_L) ? DEPTH_L : ctx_len;
  assign start_iter = (iter_num == '0) ? ITW'(1) : iter_num;
  assign pc_inc     = pc + AW'(1);
  assign last_ctx   = (({1'b0, pc} + (AW+1)'(1)) == len);
  assign last_iter  = (iter == iter_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (start_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort_i)                              state_nxt = S_DONE;
        else if (!stall && last_ctx && last_iter) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == S_RUN);
    inst_valid = (state == S_RUN);
    done       = (state == S_DONE);
  end

  // Context memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cfg_err <= 1'b0;
    else if (cfg_we && busy) cfg_err <= 1'b1;
  end

  // Issue datapath: inst always reflects mem[pc] while RUN, zero otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst     <= '0;
      pc       <= '0;
      iter     <= '0;
      len      <= '0;
      iter_eff <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (start_len != '0)) begin
            pc       <= '0;
            iter     <= ITW'(1);
            len      <= start_len;
            iter_eff <= start_iter;
            inst     <= mem[0];
          end
        end
        S_RUN: begin
          if (abort_i) begin
            inst <= '0;
            pc   <= '0;
          end else if (!stall) begin
            if (!last_ctx) begin
              pc   <= pc_inc;
              inst <= mem[pc_inc];
            end else if (!last_iter) begin
              pc   <= '0;
              iter <= iter + ITW'(1);
              inst <= mem[0];
            end else begin
              pc   <= '0;
              inst <= '0;
            end
          end
        end
        default: inst <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Randomized bench for pe_ctx_sequencer against an issue-trace reference model.
module tb_pe_ctx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [47:0] cfg_data;
  logic        start;
  logic [4:0]  ctx_len;
  logic [15:0] iter_num;
  logic        stall;
  logic [47:0] inst;
  logic        inst_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef PE_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] mdl_mem [16];
  logic        mdl_err;
  logic [47:0] q_inst [$];
  int          q_pc   [$];

  pe_ctx_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .ctx_len(ctx_len), .iter_num(iter_num), .stall(stall),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .busy(busy), .done(done),
    .cfg_err(cfg_err)
`ifdef PE_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_slot(input int a, input logic [47:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_data = d;
    mdl_mem[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // stall_mode: 0 none, 1 random, 2 two stall cycles on the first pc==1
  task automatic run_seq(input int len_in, input int it_in, input int stall_mode, input bit bad_wr);
    int len_e, it_e, cyc, stalls, dir;
    len_e = (len_in > 16) ? 16 : len_in;
    it_e  = (it_in == 0) ? 1 : it_in;
    q_inst.delete(); q_pc.delete();
    for (int i = 0; i < it_e; i++)
      for (int p = 0; p < len_e; p++) begin
        q_inst.push_back(mdl_mem[p]);
        q_pc.push_back(p);
      end
    @(negedge clk);
    start = 1'b1; ctx_len = len_in[4:0]; iter_num = it_in[15:0];
    @(negedge clk);
    start = 1'b0;
    if (len_e == 0) begin
      check_eq("zlen_done", done, 1);
      check_eq("zlen_valid", inst_valid, 0);
      check_eq("zlen_busy", busy, 0);
      @(negedge clk);
      check_eq("zlen_done_clr", done, 0);
      check_eq("zlen_valid2", inst_valid, 0);
      return;
    end
    cyc = 0; stalls = 0; dir = 0;
    while (q_inst.size() > 0 && cyc < 2000) begin
      check_eq("busy", busy, 1);
      check_eq("inst_valid", inst_valid, 1);
      check_eq("inst", inst, q_inst[0]);
      check_eq("pc", pc, q_pc[0]);
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (q_pc[0] == 1 && dir < 2);
        default: stall = 1'b0;
      endcase
      if (stall_mode == 2 && stall) dir++;
      if (bad_wr && cyc == 0) begin
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 48'hFFFF;
        mdl_err = 1'b1;
      end
      if (stall) stalls++;
      else begin
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
      end
      @(negedge clk);
      cfg_we = 1'b0;
      cyc++;
    end
    stall = 1'b0;
    check_eq("issue_left", q_inst.size(), 0);
    check_eq("busy_cycles", cyc, len_e * it_e + stalls);
    check_eq("done", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_valid", inst_valid, 0);
    check_eq("done_inst", inst, 0);
    check_eq("cfg_err", cfg_err, mdl_err);
    @(negedge clk);
    check_eq("idle_done", done, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; ctx_len = '0; iter_num = '0; stall = 1'b0;
    mdl_err = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_inst", inst, 0);
    check_eq("rst_valid", inst_valid, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", cfg_err, 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) write_slot(i, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);

    write_slot(0, 48'h07074807883f);
    run_seq(1, 1, 0, 0);

    write_slot(0, 48'd1); write_slot(1, 48'd2); write_slot(2, 48'd3);
    run_seq(3, 2, 0, 0);
    run_seq(3, 2, 2, 0);
    run_seq(3, 1, 0, 1);
    run_seq(3, 2, 0, 0);
    run_seq(0, 3, 0, 0);
    run_seq(20, 1, 0, 0);
    run_seq(2, 0, 0, 0);

    // Asynchronous reset mid-run, then replay from retained memory
    @(negedge clk);
    start = 1'b1; ctx_len = 5'd16; iter_num = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("arst_inst", inst, 0);
    check_eq("arst_valid", inst_valid, 0);
    check_eq("arst_pc", pc, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_err", cfg_err, 0);
    mdl_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_seq(16, 1, 0, 0);

`ifdef PE_SEQ_ABORT_EN
    @(negedge clk);
    start = 1'b1; ctx_len = 5'd8; iter_num = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1; stall = 1'b1;
    @(negedge clk);
    abort = 1'b0; stall = 1'b0;
    check_eq("abort_done", done, 1);
    check_eq("abort_valid", inst_valid, 0);
    check_eq("abort_inst", inst, 0);
    @(negedge clk);
    check_eq("abort_idle", done, 0);
`endif

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1)
        write_slot($urandom_range(0, 15), {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
      run_seq($urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 1),
              ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
